// File: rtl/pix_pkg.sv
// Shared definitions for the CCD line-capture block.
// Holds the line-length constants, the capture state type and the FIFO entry layout.
// Imported by pix_fifo and pix_line_capture.
package pix_pkg;

   localparam int PIX_PER_LINE_NORM = 2087;
   localparam int PIX_PER_LINE_CAL  = 2048;
   localparam int FIFO_DEPTH        = 16;
   localparam int CNT_W             = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2,
      FULL   = 2'd3
   } cap_state_t;

   typedef struct packed {
      logic [15:0] dat;
      logic        first;
      logic        last;
   } pix_entry_t;

   // Expected pixels per line for the latched calibration selection.
   function automatic logic [CNT_W-1:0] line_len(input logic cal);
      return cal ? CNT_W'(PIX_PER_LINE_CAL) : CNT_W'(PIX_PER_LINE_NORM);
   endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous single-clock FIFO of pixel entries with flush.
// Latency: a push is visible at the head (empty deasserts) the cycle after it is written.
// Backpressure: push while full is ignored (caller flags it); pop while empty is ignored.
// Ports: clk/rst (async, active-high), flush (synchronous clear), push/push_dat,
//        pop, head (zero when empty), full, empty.
module pix_fifo
   import pix_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  pix_entry_t push_dat,
   input  logic       pop,
   output pix_entry_t head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   pix_entry_t     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    used;
   logic           do_push;
   logic           do_pop;

   assign full    = (used == (AW+1)'(DEPTH));
   assign empty   = (used == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head is forced to zero when empty so the stream outputs read zero at rest.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         used <= used + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: it is only observed through head, which is gated by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/pix_line_capture.sv
// Captures CCD pixel words per line into a 16-deep stream FIFO with first/last tags.
// Latency: detected pix_clk fall -> m_valid is 2 cycles; stream sustains 1 word/cycle.
// Backpressure: m_ready low fills the FIFO; further pixels are dropped and err_ovf is set.
// Ports: clk_80M, rst (async, active-high), en, cal_mode, pix_clk, pix_data, ccd_sh,
//        clr_err; stream m_data/m_valid/m_ready/m_first/m_last; line_cnt; err_ovf,
//        err_short, err_long (sticky).
module pix_line_capture
   import pix_pkg::*;
(
   input  logic        clk_80M,
   input  logic        rst,
   input  logic        en,
   input  logic        cal_mode,
   input  logic        pix_clk,
   input  logic [15:0] pix_data,
   input  logic        ccd_sh,
   input  logic        clr_err,
   output logic [15:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_first,
   output logic        m_last,
   output logic [15:0] line_cnt,
   output logic        err_ovf,
   output logic        err_short,
   output logic        err_long
);

   // [0],[1] synchronizer flops, [2] edge-detect flop.
   logic [2:0]       pix_sync;
   logic [2:0]       sh_sync;
   logic             pix_evt;
   logic             sh_evt;
   logic [15:0]      pix_q;

   cap_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] n_len;
   logic             cal_lat, cal_nxt;
   logic [15:0]      line_nxt;
   logic             push_vld, push_nxt;
   pix_entry_t       push_dat, push_dat_nxt;
   logic             set_short, set_long, set_ovf;

   pix_entry_t       head;
   logic             fifo_full, fifo_empty;

   assign pix_evt = pix_sync[2] & ~pix_sync[1];
   assign sh_evt  = sh_sync[1] & ~sh_sync[2];

   always_ff @(posedge clk_80M or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Pixel is handled before a coincident line event: a pixel completing the line
   // moves the working state to FULL, so the same-cycle line event closes it cleanly.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      cal_nxt      = cal_lat;
      line_nxt     = line_cnt;
      push_nxt     = 1'b0;
      push_dat_nxt = push_dat;
      set_short    = 1'b0;
      set_long     = 1'b0;
      n_len        = line_len(cal_lat);
      if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         line_nxt  = '0;
      end else begin
         case (state)
            IDLE: state_nxt = SYNC;
            SYNC: begin
               // Pixels before the first line boundary belong to a partial line.
               if (sh_evt) begin
                  state_nxt = ACTIVE;
                  cnt_nxt   = '0;
                  cal_nxt   = cal_mode;
               end
            end
            ACTIVE: begin
               if (pix_evt) begin
                  push_nxt     = 1'b1;
                  push_dat_nxt = '{dat:   pix_q,
                                   first: (cnt == '0),
                                   last:  (cnt == n_len - CNT_W'(1))};
                  cnt_nxt      = cnt + CNT_W'(1);
                  if (cnt_nxt == n_len) state_nxt = FULL;
               end
               if (sh_evt) begin
                  if (state_nxt == FULL) begin
                     cnt_nxt   = '0;
                     line_nxt  = line_cnt + 16'd1;
                     state_nxt = ACTIVE;
                     cal_nxt   = cal_mode;
                  end else if (cnt_nxt != '0) begin
                     set_short = 1'b1;
                     cnt_nxt   = '0;
                  end
               end
            end
            FULL: begin
               if (pix_evt) set_long = 1'b1;
               if (sh_evt) begin
                  cnt_nxt   = '0;
                  line_nxt  = line_cnt + 16'd1;
                  state_nxt = ACTIVE;
                  cal_nxt   = cal_mode;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A push landing on a full FIFO is an overflow; pushes killed by a flush are not.
   assign set_ovf = push_vld && fifo_full && en;

   always_ff @(posedge clk_80M or posedge rst) begin
      if (rst) begin
         pix_sync  <= '0;
         sh_sync   <= '0;
         pix_q     <= '0;
         cnt       <= '0;
         cal_lat   <= 1'b0;
         line_cnt  <= '0;
         push_vld  <= 1'b0;
         push_dat  <= '0;
         err_ovf   <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
      end else begin
         pix_sync  <= {pix_sync[1:0], pix_clk};
         sh_sync   <= {sh_sync[1:0], ccd_sh};
         pix_q     <= pix_data;
         cnt       <= cnt_nxt;
         cal_lat   <= cal_nxt;
         line_cnt  <= line_nxt;
         push_vld  <= push_nxt;
         push_dat  <= push_dat_nxt;
         // Set wins over a same-cycle clear.
         err_ovf   <= set_ovf   | (err_ovf   & ~clr_err);
         err_short <= set_short | (err_short & ~clr_err);
         err_long  <= set_long  | (err_long  & ~clr_err);
      end
   end

   pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk_80M),
      .rst      (rst),
      .flush    (~en),
      .push     (push_vld),
      .push_dat (push_dat),
      .pop      (m_valid & m_ready),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign m_valid = ~fifo_empty;
   assign m_data  = head.dat;
   assign m_first = head.first;
   assign m_last  = head.last;

endmodule

// File: tb/tb_pix_line_capture.sv
`timescale 1ns/1ps
module tb_pix_line_capture;

   logic        clk_80M = 1'b0;
   logic        rst, en, cal_mode, pix_clk, ccd_sh, clr_err, m_ready;
   logic [15:0] pix_data;
   logic [15:0] m_data, line_cnt;
   logic        m_valid, m_first, m_last, err_ovf, err_short, err_long;

   always #6.25 clk_80M = ~clk_80M;

   pix_line_capture dut (
      .clk_80M   (clk_80M),
      .rst       (rst),
      .en        (en),
      .cal_mode  (cal_mode),
      .pix_clk   (pix_clk),
      .pix_data  (pix_data),
      .ccd_sh    (ccd_sh),
      .clr_err   (clr_err),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_first   (m_first),
      .m_last    (m_last),
      .line_cnt  (line_cnt),
      .err_ovf   (err_ovf),
      .err_short (err_short),
      .err_long  (err_long)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [15:0] dat;
      logic        first;
      logic        last;
   } exp_t;

   // Reference model: expected stream words and line-level bookkeeping.
   exp_t exp_q[$];
   bit   mdl_sync;
   int   mdl_idx;
   int   mdl_n;
   int   mdl_lines;
   bit   mdl_ovf, mdl_short, mdl_long;

   int   rx_words, rx_first, rx_last, last_dat;
   bit   rnd_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   function automatic void mdl_pixel(input logic [15:0] d);
      if (!mdl_sync) return;
      if (mdl_idx >= mdl_n) begin
         mdl_long = 1'b1;
         return;
      end
      if (exp_q.size() >= 16) mdl_ovf = 1'b1;
      else exp_q.push_back('{dat: d, first: (mdl_idx == 0), last: (mdl_idx == mdl_n - 1)});
      mdl_idx++;
   endfunction

   function automatic void mdl_line();
      if (!mdl_sync) begin
         mdl_sync = 1'b1;
         mdl_idx  = 0;
         mdl_n    = cal_mode ? 2048 : 2087;
      end else if (mdl_idx >= mdl_n) begin
         mdl_lines = (mdl_lines + 1) & 16'hFFFF;
         mdl_idx   = 0;
         mdl_n     = cal_mode ? 2048 : 2087;
      end else if (mdl_idx > 0) begin
         mdl_short = 1'b1;
         mdl_idx   = 0;
      end
   endfunction

   // Stream checker: every accepted word must be the next expected one.
   always @(negedge clk_80M) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_word: got data 0x%0h first %0b last %0b, expected no word at %0t",
                     m_data, m_first, m_last, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stream", {14'd0, m_data, m_first, m_last}, {14'd0, e});
         end
         rx_words++;
         if (m_first) rx_first++;
         if (m_last) begin
            rx_last++;
            last_dat = m_data;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk_80M);
         #1;
         if (rnd_on) m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #1200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_80M);
         #1;
      end
   endtask

   task automatic pixel(input logic [15:0] d);
      pix_clk = 1'b1;
      tick(2);
      pix_clk  = 1'b0;
      pix_data = d;
      mdl_pixel(d);
      tick(2);
   endtask

   task automatic line_evt();
      ccd_sh = 1'b1;
      mdl_line();
      tick(3);
      ccd_sh = 1'b0;
      tick(2);
   endtask

   // Last pixel of a line and the line boundary land in the same cycle.
   task automatic pix_sh(input logic [15:0] d);
      pix_clk = 1'b1;
      tick(2);
      pix_clk  = 1'b0;
      ccd_sh   = 1'b1;
      pix_data = d;
      mdl_pixel(d);
      mdl_line();
      tick(3);
      ccd_sh = 1'b0;
      tick(2);
   endtask

   task automatic measure_latency(input logic [15:0] d);
      int k;
      k = 0;
      pix_clk = 1'b1;
      tick(2);
      pix_clk  = 1'b0;
      pix_data = d;
      mdl_pixel(d);
      while (k < 10 && !m_valid) begin
         tick();
         k++;
      end
      chk("latency_fall_to_valid", k, 4);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         tick();
         k++;
      end
      tick(4);
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_idle_valid"}, m_valid, 0);
   endtask

   task automatic chk_status(input string name);
      chk({name, "_line_cnt"}, line_cnt, mdl_lines);
      chk({name, "_flags"}, {err_ovf, err_short, err_long}, {mdl_ovf, mdl_short, mdl_long});
   endtask

   task automatic rx_clear();
      rx_words = 0;
      rx_first = 0;
      rx_last  = 0;
      last_dat = -1;
   endtask

   task automatic enable_fresh(input logic cal);
      en = 1'b0;
      tick(3);
      exp_q.delete();
      mdl_sync  = 1'b0;
      mdl_idx   = 0;
      mdl_lines = 0;
      cal_mode  = cal;
      en        = 1'b1;
      tick(3);
      rx_clear();
   endtask

   task automatic clear_errors();
      clr_err = 1'b1;
      tick();
      clr_err   = 1'b0;
      mdl_ovf   = 1'b0;
      mdl_short = 1'b0;
      mdl_long  = 1'b0;
      tick();
   endtask

   initial begin
      int kind, len, k;
      rst = 1'b1; en = 1'b0; cal_mode = 1'b0; pix_clk = 1'b0; ccd_sh = 1'b0;
      clr_err = 1'b0; m_ready = 1'b1; pix_data = '0;
      mdl_sync = 0; mdl_idx = 0; mdl_n = 2087; mdl_lines = 0;
      mdl_ovf = 0; mdl_short = 0; mdl_long = 0;
      rx_clear();
      tick(3);
      chk("reset_outputs", {m_valid, m_first, m_last, err_ovf, err_short, err_long, m_data, line_cnt}, 0);
      rst = 1'b0;
      tick(2);

      // Normal-mode line, preceded by pixels that must be discarded.
      enable_fresh(1'b0);
      for (int i = 0; i < 5; i++) pixel(16'($urandom));
      tick(8);
      chk("presync_no_words", rx_words, 0);
      line_evt();
      measure_latency(16'd0);
      for (int i = 1; i < 2087; i++) pixel(16'(i));
      line_evt();
      drain("norm");
      chk_status("norm");
      chk("norm_words", rx_words, 2087);
      chk("norm_first_cnt", rx_first, 1);
      chk("norm_last_cnt", rx_last, 1);
      chk("norm_last_data", last_dat, 2086);
      chk("norm_line_cnt_lit", line_cnt, 1);
      chk("norm_flags_lit", {err_ovf, err_short, err_long}, 0);

      // Calibration-mode line.
      enable_fresh(1'b1);
      line_evt();
      for (int i = 0; i < 2048; i++) pixel(16'(i));
      line_evt();
      drain("cal");
      chk_status("cal");
      chk("cal_last_data", last_dat, 2047);
      chk("cal_last_cnt", rx_last, 1);
      chk("cal_line_cnt_lit", line_cnt, 1);

      // Short line followed by a clean full line ending with coincident pixel + boundary.
      enable_fresh(1'b0);
      line_evt();
      for (int i = 0; i < 1000; i++) pixel(16'($urandom));
      line_evt();
      drain("short");
      chk("short_flag_lit", err_short, 1);
      chk("short_line_cnt_lit", line_cnt, 0);
      chk("short_no_last", rx_last, 0);
      for (int i = 0; i < 2086; i++) pixel(16'($urandom));
      pix_sh(16'hBEEF);
      drain("after_short");
      chk_status("after_short");
      chk("after_short_line_cnt_lit", line_cnt, 1);
      chk("after_short_last_cnt", rx_last, 1);
      chk("after_short_last_data", last_dat, 16'hBEEF);

      // Overflow under backpressure, recovery, and flag clear.
      clear_errors();
      chk("clr_flags", {err_ovf, err_short, err_long}, 0);
      enable_fresh(1'b1);
      line_evt();
      for (int i = 0; i < 100; i++) pixel(16'($urandom));
      drain("pre_ovf");
      m_ready = 1'b0;
      for (int i = 0; i < 20; i++) pixel(16'($urandom));
      tick(8);
      chk("ovf_flag_lit", err_ovf, 1);
      m_ready = 1'b1;
      k = 0;
      while (m_valid && k < 40) begin
         tick();
         k++;
      end
      chk("ovf_burst_len", k, 16);
      for (int i = 120; i < 2048; i++) pixel(16'($urandom));
      line_evt();
      drain("ovf");
      chk_status("ovf");
      chk("ovf_words", rx_words, 2044);
      chk("ovf_last_cnt", rx_last, 1);
      clear_errors();
      chk("ovf_cleared", err_ovf, 0);

      // Randomized lines with random backpressure and mid-line cal_mode changes.
      enable_fresh(1'($urandom_range(0, 1)));
      rnd_on = 1'b1;
      line_evt();
      for (int ln = 0; ln < 3; ln++) begin
         kind = (ln == 2) ? 0 : int'($urandom_range(0, 2));
         if (kind == 0) len = int'($urandom_range(1, 400));
         else if (kind == 1) len = mdl_n;
         else len = mdl_n + int'($urandom_range(1, 3));
         for (int i = 0; i < len; i++) begin
            if (i == 10) cal_mode = 1'($urandom_range(0, 1));
            if (i == len - 1 && kind == 1 && $urandom_range(0, 1) == 1) pix_sh(16'($urandom));
            else pixel(16'($urandom));
         end
         if (!(kind == 1 && mdl_idx == 0)) line_evt();
      end
      tick(2);
      rnd_on  = 1'b0;
      m_ready = 1'b1;
      drain("rand");
      chk_status("rand");

      // Reset mid-line, then an over-long line.
      clear_errors();
      enable_fresh(1'b0);
      line_evt();
      for (int i = 0; i < 50; i++) pixel(16'($urandom));
      rst = 1'b1;
      exp_q.delete();
      mdl_sync = 0; mdl_idx = 0; mdl_lines = 0;
      mdl_ovf = 0; mdl_short = 0; mdl_long = 0;
      tick();
      chk("midline_rst_outputs",
          {m_valid, m_first, m_last, err_ovf, err_short, err_long, m_data, line_cnt}, 0);
      tick(2);
      rst = 1'b0;
      tick(3);
      rx_clear();
      for (int i = 0; i < 3; i++) pixel(16'($urandom));
      tick(8);
      chk("post_rst_discard", rx_words, 0);
      line_evt();
      for (int i = 0; i < 2088; i++) pixel(16'($urandom));
      drain("long");
      chk("long_flag_lit", err_long, 1);
      chk("long_words", rx_words, 2087);
      line_evt();
      tick(4);
      chk_status("long");
      en = 1'b0;
      tick(2);
      chk("disable_line_cnt", line_cnt, 0);
      chk("disable_keeps_flag", err_long, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
